// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU definitions for the sequential multiplier: FSM state codes and
// the number of shift-add iterations.
package alu_mul_seq_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_ITER = 8;
  localparam logic [2:0] MUL_LAST = 3'(MUL_ITER - 1);

endpackage

// File: rtl/alu_mul_seq_cla.sv
// 8-bit carry-lookahead adder/subtractor (mode=1 subtracts b from a).
// Every carry is formed directly from the generate/propagate terms.
module alu_mul_seq_cla (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       mode,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovfl
);

  logic [7:0] b_eff;
  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] carry;
  logic       c0;

  assign c0 = mode ? 1'b1 : cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pg
      assign b_eff[gi] = b[gi] ^ mode;
      assign p[gi]     = a[gi] ^ b_eff[gi];
      assign g[gi]     = a[gi] & b_eff[gi];
    end
  endgenerate

  // carry[i] = OR over j<i of g[j] & p[j+1..i-1], plus c0 & p[0..i-1]
  always_comb begin
    logic term;
    logic acc;
    carry    = '0;
    carry[0] = c0;
    for (int i = 1; i <= 8; i++) begin
      term = c0;
      for (int k = 0; k < i; k++) term = term & p[k];
      acc = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        acc = acc | term;
      end
      carry[i] = acc;
    end
  end

  assign sum  = p ^ carry[7:0];
  assign cout = carry[8];
  assign ovfl = carry[8] ^ carry[7];

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8 shift-add multiplier built on the shared CLA adder, with
// valid/ready handshakes on the operand and product sides.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] product,
  output logic        ovfl,
  output logic        busy
);

  mul_state_e state_q, state_d;
  logic [7:0] m_q, m_d;
  logic [7:0] a_q, a_d;
  logic [7:0] q_q, q_d;
  logic       c_q, c_d;
  logic [2:0] cnt_q, cnt_d;

  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_ovfl_unused;

  assign add_b = q_q[0] ? m_q : 8'h00;

  alu_mul_seq_cla u_cla (
    .a    (a_q),
    .b    (add_b),
    .cin  (c_q),
    .mode (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .ovfl (add_ovfl_unused)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = MUL_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_valid) begin
            m_d   = op_a;
            q_d   = op_b;
            a_d   = '0;
            c_d   = 1'b0;
            cnt_d = '0;
            if (SKIP_ZERO && ((op_a == 8'h00) || (op_b == 8'h00))) begin
              q_d     = '0;
              state_d = MUL_DONE;
            end else begin
              state_d = MUL_CALC;
            end
          end
        end
        MUL_CALC: begin
          // Add M when the current multiplier bit is set, then shift {cout,sum,Q} right.
          {c_d, a_d, q_d} = {1'b0, add_cout, add_sum, q_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == MUL_LAST) state_d = MUL_DONE;
        end
        MUL_DONE: begin
          if (res_ready) state_d = MUL_IDLE;
        end
        default: state_d = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == MUL_IDLE);
  assign res_valid   = (state_q == MUL_DONE);
  assign busy        = (state_q != MUL_IDLE);
  assign product     = {a_q, q_q};
  assign ovfl        = |a_q;

endmodule
